// File: rtl/pwm_sched_pkg.sv
// Shared defaults and grant encoding for the PWM value scheduler.
// Optional feature macro: PWM_SCHED_HOLD_EN (see pwm_value_scheduler).
package pwm_sched_pkg;

  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_VALUE_W      = 16;
  localparam int DEF_ADDR_W       = 11;
  localparam int CH_W             = 3;

  typedef enum logic [0:0] {
    GRANT_SPI  = 1'b0,
    GRANT_FADE = 1'b1
  } grant_e;

  // One-hot grant vector: bit 0 = SPI, bit 1 = fade
  function automatic logic [1:0] grant_onehot(input grant_e g);
    return (g == GRANT_SPI) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/pwm_sched_rr_arb.sv
// Two-way round-robin arbiter for the shadow-bank write port.
// A lone requester always wins; last_grant only moves when both contend.
module pwm_sched_rr_arb
  import pwm_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_spi,
  input  logic       req_fade,
  output logic [1:0] grant
);

  grant_e last_grant_r;
  grant_e winner_s;
  logic   tie_s;

  assign tie_s = req_spi & req_fade;

  // Pick the winner: the lone requester, or the side not granted last on a tie
  always_comb begin
    winner_s = GRANT_SPI;
    if (tie_s) begin
      winner_s = (last_grant_r == GRANT_FADE) ? GRANT_SPI : GRANT_FADE;
    end else if (req_fade) begin
      winner_s = GRANT_FADE;
    end else begin
      winner_s = GRANT_SPI;
    end
  end

  assign grant = (req_spi | req_fade) ? grant_onehot(winner_s) : 2'b00;

  // Remember the tie winner
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_r <= GRANT_FADE;
    end else if (tie_s) begin
      last_grant_r <= winner_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/pwm_value_scheduler.sv
// Shadow/active PWM duty bank fed by SPI and a fade engine; commits only at period_start.
// Optional macro PWM_SCHED_HOLD_EN adds hold_commit to defer commits for atomic updates.
module pwm_value_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int VALUE_W      = DEF_VALUE_W,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            spi_strobe,
  input  logic [ADDR_W-1:0]               spi_address,
  input  logic [VALUE_W-1:0]              spi_data,
  input  logic                            fade_req,
  input  logic [CH_W-1:0]                 fade_channel,
  input  logic [VALUE_W-1:0]              fade_value,
  output logic                            fade_ack,
  input  logic                            period_start,
`ifdef PWM_SCHED_HOLD_EN
  input  logic                            hold_commit,
`endif
  output logic [NUM_CHANNELS*VALUE_W-1:0] active_values,
  output logic [NUM_CHANNELS-1:0]         dirty,
  output logic                            spi_overrun
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_CHANNELS);

  logic                                 spi_take_s;
  logic                                 hold_valid_r;
  logic [CH_W-1:0]                      hold_ch_r;
  logic [VALUE_W-1:0]                   hold_data_r;
  logic                                 fade_ack_r;
  logic                                 spi_overrun_r;
  logic [1:0]                           grant_s;
  logic [VALUE_W-1:0]                   wr_data_s;
  logic [NUM_CHANNELS-1:0]              wr_mask_s;
  logic [NUM_CHANNELS-1:0]              commit_mask_s;
  logic [NUM_CHANNELS-1:0]              dirty_r;
  logic                                 commit_allow_s;
  logic                                 commit_en_s;
  logic [NUM_CHANNELS-1:0][VALUE_W-1:0] shadow_r;
  logic [NUM_CHANNELS-1:0][VALUE_W-1:0] active_r;

  assign spi_take_s = spi_strobe & (spi_address < ADDR_LIMIT);

  // A fade request seen during its own ack cycle is stale and must not write twice
  pwm_sched_rr_arb u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_spi  (hold_valid_r),
    .req_fade (fade_req & ~fade_ack_r),
    .grant    (grant_s)
  );

  // Route the granted writer onto the single shadow write port
  always_comb begin
    wr_data_s = hold_data_r;
    wr_mask_s = {NUM_CHANNELS{1'b0}};
    if (grant_s[1]) begin
      wr_data_s               = fade_value;
      wr_mask_s[fade_channel] = 1'b1;
    end else if (grant_s[0]) begin
      wr_mask_s[hold_ch_r] = 1'b1;
    end else begin
      wr_mask_s = {NUM_CHANNELS{1'b0}};
    end
  end

`ifdef PWM_SCHED_HOLD_EN
  assign commit_allow_s = ~hold_commit;
`else
  assign commit_allow_s = 1'b1;
`endif

  assign commit_en_s   = period_start & (|dirty_r) & commit_allow_s;
  assign commit_mask_s = commit_en_s ? dirty_r : {NUM_CHANNELS{1'b0}};

  // SPI hold register, sticky overrun flag and fade acknowledge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_r  <= 1'b0;
      hold_ch_r     <= {CH_W{1'b0}};
      hold_data_r   <= {VALUE_W{1'b0}};
      spi_overrun_r <= 1'b0;
      fade_ack_r    <= 1'b0;
    end else begin
      if (spi_take_s) begin
        hold_valid_r <= 1'b1;
        hold_ch_r    <= spi_address[CH_W-1:0];
        hold_data_r  <= spi_data;
      end else if (grant_s[0]) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
      if (spi_take_s & hold_valid_r & ~grant_s[0]) begin
        spi_overrun_r <= 1'b1;
      end else begin
        spi_overrun_r <= spi_overrun_r;
      end
      fade_ack_r <= grant_s[1];
    end
  end

  // Shadow writes, commits from pre-write shadow, dirty set beats clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_r <= {(NUM_CHANNELS*VALUE_W){1'b0}};
      active_r <= {(NUM_CHANNELS*VALUE_W){1'b0}};
      dirty_r  <= {NUM_CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_mask_s[i]) begin
          shadow_r[i] <= wr_data_s;
        end
        if (commit_mask_s[i]) begin
          active_r[i] <= shadow_r[i];
        end
      end
      dirty_r <= (dirty_r & ~commit_mask_s) | wr_mask_s;
    end
  end

  assign active_values = active_r;
  assign dirty         = dirty_r;
  assign fade_ack      = fade_ack_r;
  assign spi_overrun   = spi_overrun_r;

endmodule
